// File: rtl/reg_debug_access_pkg.sv
// Shared types and constants for the debug register-access controller.
// Command opcodes and FSM state encoding live here so the controller and benches agree.
package reg_debug_access_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DUMP_RD,
    ST_CLEAR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/reg_debug_access.sv
// Debug-port controller giving halted-core access to the GP register file:
// single READ/WRITE, whole-file DUMP and CLEAR, with a valid/ready response channel.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for a command; only state with cmd_ready high
// ST_READ    | drive rf_read_addr with latched address, capture read data
// ST_WRITE   | single-cycle write pulse (suppressed for address 0)
// ST_DUMP_RD | sample reg[idx] for the next dump response
// ST_CLEAR   | write zero to reg[idx], idx walking 1..NUM_REGS-1
// ST_RESP    | hold response until rsp_ready; loops back to ST_DUMP_RD mid-dump
module reg_debug_access
  import reg_debug_access_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk_core,
  input  logic                  rst_core_n,
  input  logic                  core_halted,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_addr,
  input  logic [XLEN-1:0]       cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [REG_ADDR_W-1:0] rsp_addr,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_last,
  output logic [REG_ADDR_W-1:0] rf_read_addr,
  input  logic [XLEN-1:0]       rf_read_data,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data,
  output logic                  rf_wr_en
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  state_e                  state, state_nxt;
  cmd_op_e                 op_q;
  logic [REG_ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]         data_q;
  logic [REG_ADDR_W-1:0]   idx;
  logic                    cmd_fire;
  logic                    rsp_fire;

  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (!core_halted) begin
            state_nxt = ST_RESP;
          end else begin
            case (cmd_op_e'(cmd_op))
              OP_READ:  state_nxt = ST_READ;
              OP_WRITE: state_nxt = ST_WRITE;
              OP_DUMP:  state_nxt = ST_DUMP_RD;
              default:  state_nxt = ST_CLEAR;
            endcase
          end
        end
      end
      ST_READ, ST_WRITE, ST_DUMP_RD: state_nxt = ST_RESP;
      ST_CLEAR: begin
        if (!core_halted || idx == LAST_IDX) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_nxt = (op_q == OP_DUMP && !rsp_last) ? ST_DUMP_RD : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cmd_ready is qualified by reset so it reads 0 while reset is held
  // and 1 in the very first cycle after release.
  always_comb begin
    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rf_wr_en      = 1'b0;
    rf_write_addr = addr_q;
    rf_write_data = data_q;
    rf_read_addr  = addr_q;
    case (state)
      ST_IDLE:    cmd_ready = rst_core_n;
      ST_WRITE:   rf_wr_en = (addr_q != '0);
      ST_DUMP_RD: rf_read_addr = idx;
      ST_CLEAR: begin
        rf_wr_en      = core_halted;
        rf_write_addr = idx;
        rf_write_data = '0;
      end
      ST_RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      op_q     <= OP_READ;
      addr_q   <= '0;
      data_q   <= '0;
      idx      <= '0;
      rsp_addr <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      rsp_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            op_q   <= cmd_op_e'(cmd_op);
            addr_q <= cmd_addr;
            data_q <= cmd_data;
            idx    <= (cmd_op_e'(cmd_op) == OP_CLEAR) ? REG_ADDR_W'(1) : '0;
            if (!core_halted) begin
              rsp_addr <= cmd_addr;
              rsp_data <= '0;
              rsp_err  <= 1'b1;
              rsp_last <= 1'b1;
            end
          end
        end
        ST_READ: begin
          rsp_addr <= addr_q;
          rsp_data <= rf_read_data;
          rsp_err  <= 1'b0;
          rsp_last <= 1'b1;
        end
        ST_WRITE: begin
          rsp_addr <= addr_q;
          rsp_data <= data_q;
          rsp_err  <= (addr_q == '0);
          rsp_last <= 1'b1;
        end
        ST_DUMP_RD: begin
          rsp_addr <= idx;
          if (core_halted) begin
            rsp_data <= rf_read_data;
            rsp_err  <= 1'b0;
            rsp_last <= (idx == LAST_IDX);
          end else begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            rsp_last <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!core_halted) begin
            rsp_addr <= idx;
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            rsp_last <= 1'b1;
          end else if (idx == LAST_IDX) begin
            rsp_addr <= idx;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_last <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_fire && op_q == OP_DUMP && !rsp_last) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_debug_access.sv
// Self-checking bench for reg_debug_access: register-file model, response and
// write scoreboards fed by a behavioural model, directed scenarios plus random commands.
module tb_reg_debug_access;

  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst_core_n;
  logic        core_halted;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_wr_en;

  always #5 clk = ~clk;

  reg_debug_access #(.NUM_REGS(NR)) dut (
    .clk_core      (clk),
    .rst_core_n    (rst_core_n),
    .core_halted   (core_halted),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_addr      (rsp_addr),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .rsp_last      (rsp_last),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_wr_en      (rf_wr_en)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
    logic        last;
    logic        chk_addr;
  } rsp_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] rf  [NR];
  logic [31:0] mem [NR];
  rsp_t        rq[$];
  wr_t         wq[$];
  rsp_t        last_rsp;
  rsp_t        prev;
  logic        stall;
  logic        rand_rdy;
  int          checks;
  int          errors;
  int          xfer_cnt;
  int          wr_cnt;

  assign rf_read_data = rf[rf_read_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  function automatic void push_rsp(input logic [4:0] a, input logic [31:0] d,
                                   input logic e, input logic l, input logic ca);
    rsp_t r;
    r.addr = a; r.data = d; r.err = e; r.last = l; r.chk_addr = ca;
    rq.push_back(r);
  endfunction

  function automatic void push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wq.push_back(w);
  endfunction

  // Expected effect of one command on the register file and the response stream.
  function automatic void model_cmd(input logic [1:0] op, input logic [4:0] a,
                                    input logic [31:0] d, input logic halted);
    if (!halted) begin
      push_rsp(a, 32'h0, 1'b1, 1'b1, 1'b0);
      return;
    end
    case (op)
      2'b00: push_rsp(a, mem[a], 1'b0, 1'b1, 1'b1);
      2'b01: begin
        if (a != 5'd0) begin
          push_wr(a, d);
          mem[a] = d;
          push_rsp(a, d, 1'b0, 1'b1, 1'b1);
        end else begin
          push_rsp(a, d, 1'b1, 1'b1, 1'b1);
        end
      end
      2'b10: begin
        for (int i = 0; i < NR; i++)
          push_rsp(5'(i), mem[i], 1'b0, i == NR - 1, 1'b1);
      end
      default: begin
        for (int i = 1; i < NR; i++) begin
          push_wr(5'(i), 32'h0);
          mem[i] = 32'h0;
        end
        push_rsp(5'(NR - 1), 32'h0, 1'b0, 1'b1, 1'b1);
      end
    endcase
  endfunction

  task automatic preload(input int mode);
    for (int i = 0; i < NR; i++) begin
      case (mode)
        0:       rf[i] = 32'(i) * 32'h11;
        1:       rf[i] = 32'hA500_0000 | 32'(i);
        default: rf[i] = $urandom;
      endcase
      mem[i] = rf[i];
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    int t;
    t = 0;
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) fail("cmd_ready_timeout");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(cmd_ready && rq.size() == 0) && t < 3000);
    if (t >= 3000) fail("idle_timeout");
    chk("writes_drained", 32'(wq.size()), 32'd0);
    rq.delete();
    wq.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_latency2();
    @(negedge clk);
    chk("lat_n1_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_n2_valid", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    int base;
    int t;
    logic [1:0] op;
    rst_core_n = 1'b0; core_halted = 1'b1; cmd_valid = 1'b0;
    cmd_op = 2'b00; cmd_addr = 5'd0; cmd_data = 32'h0; rsp_ready = 1'b1;
    rand_rdy = 1'b0; stall = 1'b0; checks = 0; errors = 0; xfer_cnt = 0; wr_cnt = 0;
    prev = '{default: '0}; last_rsp = '{default: '0};
    for (int i = 0; i < NR; i++) begin
      rf[i] = 32'h0;
      mem[i] = 32'h0;
    end

    fork
      begin : watchdog
        #400000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
      end
      forever begin : regfile
        @(posedge clk);
        if (rf_wr_en) rf[rf_write_addr] = rf_write_data;
      end
      forever begin : ready_drv
        @(posedge clk);
        #1 rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      forever begin : compare
        @(negedge clk);
        if (!rst_core_n) begin
          stall = 1'b0;
        end else begin
          if (rf_wr_en) begin
            wr_cnt++;
            if (wq.size() == 0) begin
              fail("unexpected_write");
            end else begin
              wr_t w;
              w = wq.pop_front();
              chk("wr_addr", 32'(rf_write_addr), 32'(w.a));
              chk("wr_data", rf_write_data, w.d);
            end
          end
          if (stall) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_addr", 32'(rsp_addr), 32'(prev.addr));
            chk("stall_data", rsp_data, prev.data);
            chk("stall_err", 32'(rsp_err), 32'(prev.err));
            chk("stall_last", 32'(rsp_last), 32'(prev.last));
          end
          if (rsp_valid && rsp_ready) begin
            xfer_cnt++;
            last_rsp.addr = rsp_addr; last_rsp.data = rsp_data;
            last_rsp.err = rsp_err; last_rsp.last = rsp_last;
            if (rq.size() == 0) begin
              fail("unexpected_response");
            end else begin
              rsp_t r;
              r = rq.pop_front();
              if (r.chk_addr) chk("rsp_addr", 32'(rsp_addr), 32'(r.addr));
              chk("rsp_data", rsp_data, r.data);
              chk("rsp_err", 32'(rsp_err), 32'(r.err));
              chk("rsp_last", 32'(rsp_last), 32'(r.last));
            end
          end
          stall = rsp_valid && !rsp_ready;
          prev.addr = rsp_addr; prev.data = rsp_data;
          prev.err = rsp_err; prev.last = rsp_last;
        end
      end
    join_none

    // Reset values and first cycle after release
    #3;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("rst_rsp_last", 32'(rsp_last), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_core_n = 1'b1;
    #1 chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write 5 then read it back
    base = wr_cnt;
    model_cmd(2'b01, 5'd5, 32'hDEAD_BEEF, 1'b1);
    issue(2'b01, 5'd5, 32'hDEAD_BEEF);
    check_latency2();
    wait_idle();
    chk("write5_pulses", 32'(wr_cnt - base), 32'd1);
    model_cmd(2'b00, 5'd5, 32'h0, 1'b1);
    issue(2'b00, 5'd5, 32'h0);
    check_latency2();
    wait_idle();
    chk("read5_data", last_rsp.data, 32'hDEAD_BEEF);
    chk("read5_addr", 32'(last_rsp.addr), 32'd5);
    chk("read5_errlast", {30'd0, last_rsp.err, last_rsp.last}, 32'd1);

    // Write to register 0 is refused
    base = wr_cnt;
    model_cmd(2'b01, 5'd0, 32'h1234, 1'b1);
    issue(2'b01, 5'd0, 32'h1234);
    wait_idle();
    chk("write0_no_pulse", 32'(wr_cnt - base), 32'd0);
    chk("write0_err", 32'(last_rsp.err), 32'd1);
    model_cmd(2'b00, 5'd0, 32'h0, 1'b1);
    issue(2'b00, 5'd0, 32'h0);
    wait_idle();
    chk("read0_data", last_rsp.data, 32'h0);

    // Dump with back-pressure, plus a command presented while busy
    preload(0);
    chk("model_pin_mem7", mem[7], 32'h77);
    rand_rdy = 1'b1;
    base = xfer_cnt;
    model_cmd(2'b10, 5'd0, 32'h0, 1'b1);
    issue(2'b10, 5'd0, 32'h0);
    cmd_op = 2'b01; cmd_addr = 5'd7; cmd_data = 32'hBAD0_BAD0; cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle();
    chk("dump_count", 32'(xfer_cnt - base), 32'd32);
    chk("dump_last_addr", 32'(last_rsp.addr), 32'd31);
    chk("dump_last_data", last_rsp.data, 32'h20F);
    chk("dump_last_flag", 32'(last_rsp.last), 32'd1);
    chk("busy_cmd_ignored", rf[7], 32'h77);

    // Clear, then dump all zeros
    rand_rdy = 1'b0;
    base = wr_cnt;
    model_cmd(2'b11, 5'd0, 32'h0, 1'b1);
    issue(2'b11, 5'd0, 32'h0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 100);
    chk("clear_latency", 32'(t), 32'd32);
    wait_idle();
    chk("clear_pulses", 32'(wr_cnt - base), 32'd31);
    chk("clear_rsp_addr", 32'(last_rsp.addr), 32'd31);
    rand_rdy = 1'b1;
    model_cmd(2'b10, 5'd0, 32'h0, 1'b1);
    issue(2'b10, 5'd0, 32'h0);
    wait_idle();
    chk("clear_rf17", rf[17], 32'h0);

    // Not halted: read is refused; dump aborted after four responses
    rand_rdy = 1'b0;
    core_halted = 1'b0;
    base = wr_cnt;
    model_cmd(2'b00, 5'd3, 32'h0, 1'b0);
    issue(2'b00, 5'd3, 32'h0);
    wait_idle();
    chk("unhalted_err", {30'd0, last_rsp.err, last_rsp.last}, 32'd3);
    chk("unhalted_data", last_rsp.data, 32'h0);
    chk("unhalted_no_write", 32'(wr_cnt - base), 32'd0);
    core_halted = 1'b1;
    preload(2);
    for (int i = 0; i < 4; i++) push_rsp(5'(i), mem[i], 1'b0, 1'b0, 1'b1);
    push_rsp(5'd4, 32'h0, 1'b1, 1'b1, 1'b0);
    base = xfer_cnt;
    issue(2'b10, 5'd0, 32'h0);
    t = 0;
    while (xfer_cnt < base + 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("dump_abort_wait");
    @(posedge clk);
    #1 core_halted = 1'b0;
    wait_idle();
    chk("abort_count", 32'(xfer_cnt - base), 32'd5);
    chk("abort_errlast", {30'd0, last_rsp.err, last_rsp.last}, 32'd3);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    core_halted = 1'b1;

    // Reset in the middle of a clear
    preload(1);
    for (int i = 1; i <= 10; i++) push_wr(5'(i), 32'h0);
    issue(2'b11, 5'd0, 32'h0);
    t = 0;
    do begin
      @(negedge clk);
      #2 t++;
    end while (!(rf_wr_en && rf_write_addr == 5'd10) && t < 100);
    if (t >= 100) fail("clear_addr10_wait");
    rst_core_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(rf_wr_en), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 1; i < 10; i++) mem[i] = 32'h0;
    rq.delete();
    wq.delete();
    @(posedge clk);
    #1 rst_core_n = 1'b1;
    #1 chk("midrst_release_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_rf9", rf[9], 32'h0);
    chk("midrst_rf10", rf[10], 32'hA500_000A);
    chk("midrst_rf31", rf[31], 32'hA500_001F);
    model_cmd(2'b10, 5'd0, 32'h0, 1'b1);
    issue(2'b10, 5'd0, 32'h0);
    wait_idle();

    // Random command mix against the model
    rand_rdy = 1'b1;
    preload(2);
    for (int n = 0; n < 40; n++) begin
      int r;
      logic [4:0]  a;
      logic [31:0] d;
      logic        h;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      h = ($urandom_range(0, 5) != 0);
      core_halted = h;
      model_cmd(op, a, d, h);
      issue(op, a, d);
      wait_idle();
    end
    core_halted = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
